beta_fetch_unit: RTL
====================

// Module: beta_fetch_unit
// PURPOSE
//  Instruction fetch stage. Owns the PC, issues requests to instruction memory and buffers responses.
//  Presents one instruction per cycle (instr, new_instr, next_pc) to the IF/DEC pipeline register.
//  Applies redirects from execute (branch/jump/trap) and honours the Pipeline Control Unit stall.
// PARAMETERS
//  DataWidth   32            width of instruction, address and PC lines
//  BootAddr    32'h0000_0000 PC value after reset
//  BufDepth    2             response buffer entries (power of 2, >=2)
// PORTS
//  clk_i               in   1          clock, all state on rising edge
//  rstn_i              in   1          synchronous reset, active-low
//  imem_req_o          out  1          request valid; held until imem_gnt_i
//  imem_addr_o         out  DataWidth  request word address; stable while imem_req_o && !imem_gnt_i
//  imem_gnt_i          in   1          request accepted this cycle
//  imem_rvalid_i       in   1          response valid; exactly one per granted request, >=1 cycle after gnt
//  imem_rdata_i        in   DataWidth  response instruction
//  fet_instr_o         out  DataWidth  head instruction; NOP (32'h00000013) when buffer empty
//  fet_new_instr_o     out  1          head valid (buffer not empty)
//  fet_next_pc_o       out  DataWidth  head instruction PC + 4; 0 when empty
//  fet_stall_i         in   1          downstream stall; head is not consumed
//  fet_redirect_i      in   1          redirect/flush request
//  fet_redirect_pc_i   in   DataWidth  redirect target
//  fet_misalign_o      out  1          present only with BETA_FETCH_MISALIGN_EXC_EN
// BEHAVIOUR
//  Reset (rstn_i==0 at an edge):
//   - pc=BootAddr, state=IDLE, buffer empty, outstanding=0, kill=0.
//   - Outputs: imem_req_o=0, imem_addr_o=BootAddr, fet_new_instr_o=0, fet_instr_o=NOP, fet_next_pc_o=0.
//  FSM, one outstanding request max:
//   - IDLE -> REQ when credits free.
//   - REQ: imem_req_o=1, addr=pc. On gnt: pc+=4, go to WAIT.
//   - WAIT: on rvalid, push {rdata, addr+4} unless kill. Then REQ if credits free, else IDLE.
//   - Credits free: occupancy + outstanding < BufDepth, where the same-cycle pop counts as freed.
//  Back-to-back streaming: rvalid and the next req/gnt may occur in the same cycle.
//  Throughput is 1 instr/cycle when gnt and rvalid are both single-cycle.
//  Consume: pop head when fet_new_instr_o && !fet_stall_i. Outputs are combinational from the buffer head.
//  Latency: rvalid at cycle N -> fet_new_instr_o=1 at cycle N+1.
//  Redirect (highest priority, ignores stall):
//   - Buffer is flushed. Any pop or push in that cycle is dropped.
//   - pc <= fet_redirect_pc_i; state goes to REQ next cycle.
//   - If a response is still owed (WAIT without rvalid, or REQ with gnt this cycle): kill=1, stay in WAIT.
//     The killed rvalid is discarded, then the FSM goes to REQ. kill clears on that rvalid.
//   - The REQ->IDLE abandonment is legal only if gnt=0 this cycle; imem_req_o drops for one cycle.
//   - Redirect while kill=1: pc is updated and kill stays set. The single stale response is still dropped.
//  Full buffer plus stall: no new request is issued. Occupancy never exceeds BufDepth.
//  PC arithmetic is modulo 2^DataWidth; 32'hFFFF_FFFC + 4 wraps to 0.
//  Responses with rvalid while outstanding=0 are protocol errors (simulation assertion).
// CONFIGURATION
//  BETA_FETCH_MISALIGN_EXC_EN defined:
//   - Redirect target with [1:0]!=0 sets fet_misalign_o=1 (sticky), issues no request, and leaves the buffer empty.
//   - It clears only on the next aligned redirect or on reset (reset value 0).
//  Not defined: the port is absent and fet_redirect_pc_i[1:0] is forced to 2'b00.
// STRUCTURE
//  beta_pkg:
//   - BETA_NOP_INSTR = 32'h00000013.
//   - typedef enum logic[1:0] {FET_IDLE, FET_REQ, FET_WAIT} beta_fetch_state_t.
//   - typedef struct packed {instr, next_pc} beta_fetch_entry_t.
//  Sub-module beta_fetch_buffer: BufDepth-entry FIFO of beta_fetch_entry_t.
//   - Ports: push, pop, flush, full, empty, count. Pop+push allowed together when full.
//   - Synchronous active-low reset.
//  Top holds the FSM, PC, kill flag and credit logic.
// TESTING
//  1 Reset: rstn_i=0 for 3 cycles -> all outputs at reset values; imem_req_o=1 with addr 0 on the 1st cycle after release.
//  2 Stream: gnt always 1, rvalid 1 cycle after gnt, data = addr ^ 32'hA5A5_0000.
//    -> fet_next_pc_o 4, 8, C on consecutive cycles with matching instrs.
//  3 Stall: hold fet_stall_i=1 for 5 cycles while streaming.
//    -> fet_instr_o stable; occupancy 2; imem_req_o=0; after release, no instr lost or duplicated.
//  4 Redirect in WAIT: redirect to 32'h100 the cycle before rvalid.
//    -> stale response dropped; next request addr 32'h100; first new fet_next_pc_o=32'h104.
//  5 Redirect with gnt in same cycle, then a second redirect to 32'h200 while killed.
//    -> exactly one response dropped; next addr 32'h200.
//  6 Wrap: redirect to 32'hFFFF_FFFC -> requests FFFF_FFFC, then 0.
//    With macro: redirect to 32'h102 -> fet_misalign_o=1, no imem_req_o.

Source files
------------

// File: rtl/beta_pkg.sv
// Shared types and constants for the beta fetch stage.
// Optional misaligned-redirect trap: BETA_FETCH_MISALIGN_EXC_EN.
package beta_pkg;

  localparam int unsigned BETA_XLEN = 32;

  localparam logic [BETA_XLEN-1:0] BETA_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FET_IDLE = 2'd0,
    FET_REQ  = 2'd1,
    FET_WAIT = 2'd2
  } beta_fetch_state_t;

  typedef struct packed {
    logic [BETA_XLEN-1:0] instr;
    logic [BETA_XLEN-1:0] next_pc;
  } beta_fetch_entry_t;

endpackage

// File: rtl/beta_fetch_buffer.sv
// Fetch response FIFO: power-of-2 depth, flush, push+pop when full.
// Synchronous active-low reset.
module beta_fetch_buffer
  import beta_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      push_i,
  input  beta_fetch_entry_t         entry_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  output beta_fetch_entry_t         head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(Depth):0]    count_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  beta_fetch_entry_t mem_q [Depth];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(Depth));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= entry_i;
  end

endmodule

// File: rtl/beta_fetch_unit.sv
// Instruction fetch stage: PC, imem request FSM, kill flag, credits.
// Optional misaligned-redirect trap: BETA_FETCH_MISALIGN_EXC_EN.
module beta_fetch_unit
  import beta_pkg::*;
#(
  parameter int unsigned          DataWidth = 32,
  parameter logic [DataWidth-1:0] BootAddr  = '0,
  parameter int unsigned          BufDepth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  output logic                 imem_req_o,
  output logic [DataWidth-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DataWidth-1:0] imem_rdata_i,
  output logic [DataWidth-1:0] fet_instr_o,
  output logic                 fet_new_instr_o,
  output logic [DataWidth-1:0] fet_next_pc_o,
  input  logic                 fet_stall_i,
  input  logic                 fet_redirect_i,
  input  logic [DataWidth-1:0] fet_redirect_pc_i
`ifdef BETA_FETCH_MISALIGN_EXC_EN
  ,
  output logic                 fet_misalign_o
`endif
);

  localparam int unsigned   CW     = $clog2(BufDepth) + 1;
  localparam logic [CW-1:0] DepthC = CW'(BufDepth);

  beta_fetch_state_t    state_q, state_d;
  logic [DataWidth-1:0] pc_q, pc_d;
  logic                 kill_q, kill_d;
  logic                 mis_q;
  logic [DataWidth-1:0] redir_pc;
  logic                 redir_mis;

  beta_fetch_entry_t entry, head;
  logic              push, pop, empty, full;
  logic [CW-1:0]     count, occ;
  logic              owed, credit;

`ifdef BETA_FETCH_MISALIGN_EXC_EN
  logic mis_d;

  assign redir_pc       = fet_redirect_pc_i;
  assign redir_mis      = |fet_redirect_pc_i[1:0];
  assign mis_d          = fet_redirect_i ? redir_mis : mis_q;
  assign fet_misalign_o = mis_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) mis_q <= 1'b0;
    else         mis_q <= mis_d;
  end
`else
  assign redir_pc  = fet_redirect_pc_i & ~DataWidth'(3);
  assign redir_mis = 1'b0;
  assign mis_q     = 1'b0;
`endif

  // a response is still in flight after this cycle
  assign owed = ((state_q == FET_WAIT) && !imem_rvalid_i)
             || ((state_q == FET_REQ) && imem_gnt_i);

  assign pop    = !empty && !fet_stall_i;
  assign push   = (state_q == FET_WAIT) && imem_rvalid_i
               && !kill_q && !fet_redirect_i;
  assign occ    = count - CW'(pop) + CW'(push);
  assign credit = !mis_q && (occ < DepthC);

  assign entry = '{instr: imem_rdata_i, next_pc: pc_q};

  beta_fetch_buffer #(
    .Depth (BufDepth)
  ) u_buf (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .entry_i (entry),
    .pop_i   (pop),
    .flush_i (fet_redirect_i),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= FET_IDLE;
      pc_q    <= BootAddr;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    if (fet_redirect_i) begin
      pc_d   = redir_pc;
      kill_d = owed;
      if (owed)
        state_d = FET_WAIT;
      else if (redir_mis || (state_q == FET_REQ))
        state_d = FET_IDLE;
      else
        state_d = FET_REQ;
    end else begin
      unique case (1'b1)
        (state_q == FET_IDLE): begin
          if (credit) state_d = FET_REQ;
        end
        (state_q == FET_REQ): begin
          if (imem_gnt_i) begin
            pc_d    = pc_q + DataWidth'(4);
            state_d = FET_WAIT;
          end
        end
        (state_q == FET_WAIT): begin
          if (imem_rvalid_i) begin
            kill_d = 1'b0;
            if (imem_req_o && imem_gnt_i)
              pc_d = pc_q + DataWidth'(4);
            else
              state_d = credit ? FET_REQ : FET_IDLE;
          end
        end
        default: state_d = FET_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req_o = 1'b0;
    unique case (1'b1)
      (state_q == FET_REQ):
        imem_req_o = 1'b1;
      (state_q == FET_WAIT):
        imem_req_o = imem_rvalid_i && !kill_q
                  && !fet_redirect_i && credit;
      default:
        imem_req_o = 1'b0;
    endcase
  end

  assign imem_addr_o     = pc_q;
  assign fet_new_instr_o = !empty;
  assign fet_instr_o     = empty ? BETA_NOP_INSTR : head.instr;
  assign fet_next_pc_o   = empty ? '0 : head.next_pc;

`ifndef SYNTHESIS
  a_rvalid_owed: assert property (@(posedge clk_i)
    disable iff (!rstn_i) imem_rvalid_i |-> state_q == FET_WAIT);
  a_no_overflow: assert property (@(posedge clk_i)
    disable iff (!rstn_i) push && full |-> pop);
`endif

endmodule
